// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control path and its datapath muxes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_HALT     = 4'd10
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } srca_e;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } srcb_e;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00,
      RES_MDR    = 2'b01,
      RES_ALU    = 2'b10
   } res_e;

   typedef struct packed {
      logic    mem_req;
      logic    mem_write;
      logic    adr_src;
      logic    ir_write;
      logic    pc_write;
      logic    reg_write;
      srca_e   alu_src_a;
      srcb_e   alu_src_b;
      alu_op_e alu_op;
      res_e    result_src;
   } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_dec.sv
// Combinational state -> control-word decoder; enables are qualified by mem_ready / zero.
module ctrl_out_dec
   import ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic       mem_ready_i,
   input  logic       zero_i,
   output ctrl_word_t ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req    = 1'b1;
            ctrl_o.alu_src_a  = SRCA_PC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.alu_op     = ALU_ADD;
            ctrl_o.result_src = RES_ALU;
            ctrl_o.ir_write   = mem_ready_i;
            ctrl_o.pc_write   = mem_ready_i;
         end
         S_DECODE: begin
            // branch target lands in the ALU-out register for a later beq
            ctrl_o.alu_src_a = SRCA_OLDPC;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_MEMREAD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.adr_src = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.result_src = RES_MDR;
            ctrl_o.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            ctrl_o.adr_src   = 1'b1;
         end
         S_EXECR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_RS2;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.reg_write  = 1'b1;
         end
         S_BEQ: begin
            ctrl_o.alu_src_a  = SRCA_RS1;
            ctrl_o.alu_src_b  = SRCB_RS2;
            ctrl_o.alu_op     = ALU_SUB;
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.pc_write   = zero_i;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: next-state sequencing, sticky halt flag and retired-instruction counter.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                w_clk,
   input  logic                w_rst_n,
   input  logic [6:0]          w_opcode,
   input  logic                w_zero,
   input  logic                w_mem_ready,
   output logic                w_mem_req,
   output logic                w_mem_write,
   output logic                w_adr_src,
   output logic                w_ir_write,
   output logic                w_pc_write,
   output logic                w_reg_write,
   output logic [1:0]          w_alu_src_a,
   output logic [1:0]          w_alu_src_b,
   output logic [1:0]          w_alu_op,
   output logic [1:0]          w_result_src,
   output logic                w_halt,
   output logic [RETIRE_W-1:0] w_retired
);

   state_e                state_q, state_d;
   logic                  halt_q, halt_d;
   logic [RETIRE_W-1:0]   retired_q, retired_d;
   logic                  retire;
   ctrl_word_t            ctrl;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q   <= S_FETCH;
         halt_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         halt_q    <= halt_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (w_mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR:   state_d = (w_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (w_mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (w_mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_MEMWB:    state_d = S_FETCH;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retire    = (state_q inside {S_MEMWB, S_ALUWB, S_BEQ}) ||
                  ((state_q == S_MEMWRITE) && w_mem_ready);
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire};
      halt_d    = halt_q | (state_d == S_HALT);
   end

   ctrl_out_dec u_out_dec (
      .state_i     (state_q),
      .mem_ready_i (w_mem_ready),
      .zero_i      (w_zero),
      .ctrl_o      (ctrl)
   );

   // Write enables and the result select are forced quiet while reset is held.
   assign w_mem_req    = ctrl.mem_req;
   assign w_mem_write  = ctrl.mem_write & w_rst_n;
   assign w_adr_src    = ctrl.adr_src;
   assign w_ir_write   = ctrl.ir_write & w_rst_n;
   assign w_pc_write   = ctrl.pc_write & w_rst_n;
   assign w_reg_write  = ctrl.reg_write & w_rst_n;
   assign w_alu_src_a  = ctrl.alu_src_a;
   assign w_alu_src_b  = ctrl.alu_src_b;
   assign w_alu_op     = ctrl.alu_op;
   assign w_result_src = w_rst_n ? ctrl.result_src : RES_ALUOUT;
   assign w_halt       = halt_q;
   assign w_retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction phase-schedule model checked every cycle plus literal pins.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_ILL = 7'b1111111;

   // phases of an instruction as the schedule sees them
   localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMB = 4, PMW = 5;
   localparam int PXR = 6, PXI = 7, PAW = 8, PB = 9, PH = 10;

   // instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 illegal
   int seq [6][5] = '{'{PF, PD, PMA, PMR, PMB},
                      '{PF, PD, PMA, PMW, 0},
                      '{PF, PD, PXR, PAW, 0},
                      '{PF, PD, PXI, PAW, 0},
                      '{PF, PD, PB,  0,   0},
                      '{PF, PD, PH,  0,   0}};
   int seq_len [6] = '{5, 4, 4, 4, 3, 3};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_halt;
   logic [1:0]  w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;
   logic [31:0] w_retired;

   int n_chk  = 0;
   int n_pass = 0;

   int          m_cls = 0;
   int          m_idx = 0;
   logic [31:0] m_ret = 32'd0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.RETIRE_W(32)) dut (
      .w_clk        (clk),
      .w_rst_n      (rst_n),
      .w_opcode     (opcode),
      .w_zero       (zero),
      .w_mem_ready  (mem_ready),
      .w_mem_req    (w_mem_req),
      .w_mem_write  (w_mem_write),
      .w_adr_src    (w_adr_src),
      .w_ir_write   (w_ir_write),
      .w_pc_write   (w_pc_write),
      .w_reg_write  (w_reg_write),
      .w_alu_src_a  (w_alu_src_a),
      .w_alu_src_b  (w_alu_src_b),
      .w_alu_op     (w_alu_op),
      .w_result_src (w_result_src),
      .w_halt       (w_halt),
      .w_retired    (w_retired)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int class_of(input logic [6:0] op);
      case (op)
         OP_LW:   return 0;
         OP_SW:   return 1;
         OP_R:    return 2;
         OP_I:    return 3;
         OP_BEQ:  return 4;
         default: return 5;
      endcase
   endfunction

   // {req, write, adr, ir_wr, pc_wr, reg_wr, src_a, src_b, alu_op, result_src, halt}
   function automatic logic [14:0] exp_word(input int ph, input logic rdy, input logic zro);
      logic       req, wr, adr, irw, pcw, rw, hl;
      logic [1:0] a, b, op, rs;
      {req, wr, adr, irw, pcw, rw, hl} = '0;
      {a, b, op, rs} = '0;
      case (ph)
         PF:  begin req = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
         PD:  begin a = 2'b01; b = 2'b01; end
         PMA: begin a = 2'b10; b = 2'b01; end
         PMR: begin req = 1; adr = 1; end
         PMB: begin rs = 2'b01; rw = 1; end
         PMW: begin req = 1; wr = 1; adr = 1; end
         PXR: begin a = 2'b10; b = 2'b00; op = 2'b10; end
         PXI: begin a = 2'b10; b = 2'b01; op = 2'b10; end
         PAW: begin rw = 1; end
         PB:  begin a = 2'b10; op = 2'b01; pcw = zro; end
         PH:  begin hl = 1; end
         default: ;
      endcase
      return {req, wr, adr, irw, pcw, rw, a, b, op, rs, hl};
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int ph;
      if (!rst_n) begin
         m_cls <= 0;
         m_idx <= 0;
         m_ret <= 32'd0;
      end else begin
         ph = seq[m_cls][m_idx];
         if (ph == PD) begin
            m_cls <= class_of(opcode);
            m_idx <= 2;
         end else if (ph == PH) begin
            m_idx <= m_idx;
         end else if ((ph == PF || ph == PMR || ph == PMW) && !mem_ready) begin
            m_idx <= m_idx;
         end else if (m_idx == seq_len[m_cls] - 1) begin
            m_idx <= 0;
            m_ret <= m_ret + 32'd1;
         end else begin
            m_idx <= m_idx + 1;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [14:0] ew;
      logic [31:0] er;
      if (!rst_n) begin
         ew = {1'b1, 5'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
         er = 32'd0;
      end else begin
         ew = exp_word(seq[m_cls][m_idx], mem_ready, zero);
         er = m_ret;
      end
      chk("cycle",
          {17'd0, w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write,
           w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src, w_halt, w_retired},
          {17'd0, ew, er});
   end

   task automatic cyc(input logic rst, input logic rdy, input logic zro, input logic [6:0] op);
      @(posedge clk);
      #1;
      rst_n = rst; mem_ready = rdy; zero = zro; opcode = op;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_R;
      cyc(0, 0, 0, OP_R);
      cyc(0, 0, 0, OP_R);
      chk("rst_mem_req", w_mem_req, 1);
      chk("rst_src_b", w_alu_src_b, 2);
      chk("rst_result_src", w_result_src, 0);
      chk("rst_retired", w_retired, 0);
      cyc(0, 1, 0, OP_R);
      chk("rst_ir_write_gated", w_ir_write, 0);
      chk("rst_pc_write_gated", w_pc_write, 0);
      cyc(1, 0, 0, OP_R);
      cyc(1, 0, 0, OP_R);
      chk("stall_ir_write", w_ir_write, 0);
      chk("stall_mem_req", w_mem_req, 1);
      cyc(0, 0, 0, OP_R);
      chk("midfetch_rst_req", w_mem_req, 1);
      chk("midfetch_rst_retired", w_retired, 0);
      cyc(1, 1, 0, OP_R);
      chk("fetch_ir_write", w_ir_write, 1);
      chk("fetch_pc_write", w_pc_write, 1);

      cyc(1, 0, 0, OP_R);
      chk("r_dec_src_a", w_alu_src_a, 1);
      chk("r_dec_reg_write", w_reg_write, 0);
      cyc(1, 0, 0, OP_R);
      chk("r_exec_alu_op", w_alu_op, 2);
      chk("r_exec_src_b", w_alu_src_b, 0);
      cyc(1, 0, 0, OP_R);
      chk("r_wb_reg_write", w_reg_write, 1);
      chk("r_wb_retired", w_retired, 0);

      cyc(1, 1, 0, OP_LW);
      chk("r_done_retired", w_retired, 1);
      chk("lw_fetch_reg_write", w_reg_write, 0);
      cyc(1, 0, 0, OP_LW);
      cyc(1, 0, 0, OP_LW);
      chk("lw_memadr_src_a", w_alu_src_a, 2);
      chk("lw_memadr_src_b", w_alu_src_b, 1);
      cyc(1, 0, 0, OP_LW);
      chk("lw_wait1_req_adr", {w_mem_req, w_adr_src}, 2'b11);
      cyc(1, 0, 0, OP_LW);
      chk("lw_wait2_req_adr", {w_mem_req, w_adr_src}, 2'b11);
      cyc(1, 1, 0, OP_LW);
      chk("lw_ready_req_adr", {w_mem_req, w_adr_src}, 2'b11);
      cyc(1, 0, 0, OP_LW);
      chk("lw_memwb_reg_write", w_reg_write, 1);
      chk("lw_memwb_result_src", w_result_src, 1);

      cyc(1, 1, 0, OP_SW);
      chk("lw_done_retired", w_retired, 2);
      chk("lw_done_adr_src", w_adr_src, 0);
      cyc(1, 0, 0, OP_SW);
      cyc(1, 0, 0, OP_SW);
      chk("sw_memadr_write", w_mem_write, 0);
      cyc(1, 0, 0, OP_SW);
      chk("sw_wait_write", w_mem_write, 1);
      chk("sw_wait_reg_write", w_reg_write, 0);
      cyc(1, 1, 0, OP_SW);
      chk("sw_ready_write", w_mem_write, 1);
      chk("sw_ready_retired", w_retired, 2);

      cyc(1, 1, 0, OP_BEQ);
      chk("sw_done_retired", w_retired, 3);
      chk("sw_done_write", w_mem_write, 0);
      cyc(1, 0, 0, OP_BEQ);
      cyc(1, 0, 1, OP_BEQ);
      chk("beq_taken_pc_write", w_pc_write, 1);
      cyc(1, 1, 0, OP_BEQ);
      chk("beq_taken_retired", w_retired, 4);
      cyc(1, 0, 0, OP_BEQ);
      cyc(1, 0, 0, OP_BEQ);
      chk("beq_not_taken_pc_write", w_pc_write, 0);
      chk("beq_alu_op", w_alu_op, 1);

      cyc(1, 1, 0, OP_I);
      chk("beq_not_taken_retired", w_retired, 5);
      cyc(1, 0, 0, OP_I);
      cyc(1, 0, 0, OP_I);
      chk("i_exec_src_b", w_alu_src_b, 1);
      chk("i_exec_alu_op", w_alu_op, 2);
      cyc(1, 0, 0, OP_I);

      cyc(1, 1, 0, OP_ILL);
      chk("i_done_retired", w_retired, 6);
      cyc(1, 0, 0, OP_ILL);
      for (int i = 0; i < 20; i++) cyc(1, i[0], 0, OP_ILL);
      chk("halt_flag", w_halt, 1);
      chk("halt_mem_req", w_mem_req, 0);
      chk("halt_retired", w_retired, 6);
      chk("halt_ir_write", w_ir_write, 0);
      cyc(0, 0, 0, OP_R);
      chk("halt_rst_flag", w_halt, 0);
      chk("halt_rst_mem_req", w_mem_req, 1);
      cyc(1, 0, 0, OP_R);
      cyc(1, 0, 0, OP_R);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared datapath (RF, ALU, imm gen, unified memory) as a multi-cycle RV32I-subset core, replacing the toggle-based PC-update scheme.
- Decodes the latched opcode, drives mux selects and write enables per state, and handshakes with the unified instruction/data memory.
- Supported instructions: lw, sw, R-type ALU, I-type ALU and beq. Any other opcode halts the core.
- Also counts retired instructions.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter.
- OP_LW/OP_SW/OP_R/OP_I/OP_BEQ, 7'b0000011/7'b0100011/7'b0110011/7'b0010011/7'b1100011, opcode constants.

Ports:
- w_clk  input  1  clock, rising edge.
- w_rst_n  input  1  asynchronous, active-low reset.
- w_opcode  input  7  opcode from instruction register (IR[6:0]).
- w_zero  input  1  ALU zero flag.
- w_mem_ready  input  1  memory completes the current access this cycle.
- w_mem_req  output  1  memory access request.
- w_mem_write  output  1  write strobe (valid with w_mem_req).
- w_adr_src  output  1  memory address select: 0 = PC, 1 = ALU-out register.
- w_ir_write  output  1  latch fetched word into IR and old-PC register.
- w_pc_write  output  1  load PC from result bus.
- w_reg_write  output  1  RF write enable.
- w_alu_src_a  output  2  ALU operand A select: 00 = PC, 01 = old PC, 10 = rs1 register.
- w_alu_src_b  output  2  ALU operand B select: 00 = rs2 register, 01 = imm, 10 = constant 4.
- w_alu_op  output  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- w_result_src  output  2  result bus select: 00 = ALU-out register, 01 = memory data register, 10 = ALU direct.
- w_halt  output  1  sticky halt indicator.
- w_retired  output  RETIRE_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, HALT. Moore outputs, except the enables qualified by w_mem_ready or w_zero, as stated below.
- Reset (w_rst_n low, asynchronous): state = FETCH, w_retired = 0, w_halt = 0. All outputs 0 except those FETCH drives: w_mem_req = 1, w_alu_src_b = 10.
- Reset asserted mid-operation aborts the instruction immediately; no write enable may be high while w_rst_n is low.
- FETCH: w_mem_req = 1, w_adr_src = 0, w_alu_src_a = 00, w_alu_src_b = 10, w_alu_op = 00, w_result_src = 10.
  - Stays in FETCH while w_mem_ready = 0.
  - In the w_mem_ready = 1 cycle: w_ir_write = 1 and w_pc_write = 1 (PC <= PC+4), then go to DECODE.
- DECODE: w_alu_src_a = 01, w_alu_src_b = 01, w_alu_op = 00 (branch target precomputed into the ALU-out register). Next state by w_opcode:
  - OP_LW or OP_SW -> MEMADR
  - OP_R -> EXECR
  - OP_I -> EXECI
  - OP_BEQ -> BEQ
  - any other opcode -> HALT
- MEMADR: w_alu_src_a = 10, w_alu_src_b = 01, w_alu_op = 00. Go to MEMREAD if w_opcode == OP_LW, otherwise MEMWRITE.
- MEMREAD: w_mem_req = 1, w_adr_src = 1. Wait for w_mem_ready, then go to MEMWB.
- MEMWB: w_result_src = 01, w_reg_write = 1, retire, go to FETCH.
- MEMWRITE: w_mem_req = 1, w_mem_write = 1, w_adr_src = 1. Held until w_mem_ready; in the ready cycle retire and go to FETCH.
- EXECR: w_alu_src_a = 10, w_alu_src_b = 00, w_alu_op = 10, go to ALUWB.
- EXECI: w_alu_src_a = 10, w_alu_src_b = 01, w_alu_op = 10, go to ALUWB.
- ALUWB: w_result_src = 00, w_reg_write = 1, retire, go to FETCH.
- BEQ: w_alu_src_a = 10, w_alu_src_b = 00, w_alu_op = 01, w_result_src = 00. w_pc_write = w_zero. Retire, go to FETCH.
- HALT: w_halt = 1, all enables 0, w_mem_req = 0. Absorbing until reset.
- Handshake: w_mem_req, w_adr_src and w_mem_write are held stable until w_mem_ready is sampled high on a rising edge. w_mem_ready while w_mem_req = 0 is ignored.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each memory wait cycle adds 1.
- w_retired: +1 per retire event, wraps modulo 2^RETIRE_W. Illegal opcodes do not retire.
- The opcode is sampled only in DECODE and MEMADR; IR is stable at those points.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4-bit encoding)
  - opcode constants
  - ALU-op, src-A, src-B and result-src encodings
- Datapath muxes reference the same encodings from ctrl_pkg.
- Natural sub-module: ctrl_out_dec, a combinational state -> control-word decoder. The FSM keeps only next-state logic, the halt flag and the retire counter.

Test Plan:
- Reset mid-FETCH with w_mem_ready stuck at 0 -> outputs at reset values, w_retired = 0. Release, assert ready -> w_ir_write = 1 and w_pc_write = 1 in the same cycle.
- Opcode 0110011, w_mem_ready = 1 -> states FETCH, DECODE, EXECR, ALUWB. w_reg_write = 1 in cycle 4 only, w_retired goes 0 -> 1.
- lw (0000011) with 2 wait cycles in MEMREAD -> w_mem_req = 1 and w_adr_src = 1 held 3 cycles, MEMWB writes the RF, total 7 cycles.
- sw (0100011) -> w_mem_write = 1 only in MEMWRITE, w_reg_write never 1, retire on the ready cycle.
- beq with w_zero = 1 -> w_pc_write = 1 in BEQ. Repeat with w_zero = 0 -> w_pc_write = 0. Both retire.
- Opcode 1111111 -> HALT, w_halt = 1, w_mem_req = 0 and w_retired frozen for 20 cycles. Reset clears w_halt.
